// File: rtl/mission_pkg.sv
// Shared types and health helpers for the inspection mission sequencer.
// State codes 0-4 match the earlier single-target task FSM; FAULT extends it.
package mission_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_NAVIGATE = 3'd1,
    ST_INSPECT  = 3'd2,
    ST_TRANSMIT = 3'd3,
    ST_COMPLETE = 3'd4,
    ST_FAULT    = 3'd5
  } mission_state_e;

  // Health codes are carried at this width and truncated to HEALTH_W at use,
  // so HEALTH_CRIT narrows to the all-ones code of any width up to this.
  localparam int HEALTH_MAX_W = 16;
  localparam logic [HEALTH_MAX_W-1:0] HEALTH_OK   = '0;
  localparam logic [HEALTH_MAX_W-1:0] HEALTH_CRIT = '1;

  function automatic logic [HEALTH_MAX_W-1:0] max_health(
    input logic [HEALTH_MAX_W-1:0] a,
    input logic [HEALTH_MAX_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nav_watchdog.sv
// Navigation watchdog: per-attempt cycle timer plus bounded retry counter.
// A timeout fires on the cycle the timer sits at NAV_TIMEOUT-1 with no hit.
module nav_watchdog
  import mission_pkg::*;
#(
  parameter int NAV_TIMEOUT = 1000,
  parameter int MAX_RETRIES = 2,
  parameter int RC_W        = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            enable,
  input  logic            hit,
  output logic            retry,
  output logic            exhausted,
  output logic [RC_W-1:0] retry_count
);

  localparam int TW = (NAV_TIMEOUT > 1) ? $clog2(NAV_TIMEOUT) : 1;

  logic [TW-1:0] timer;
  logic          timeout;
  logic          at_max;

  assign timeout   = enable && !hit && (timer == TW'(NAV_TIMEOUT - 1));
  assign at_max    = (retry_count >= RC_W'(MAX_RETRIES));
  assign exhausted = timeout && at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer       <= '0;
      retry_count <= '0;
      retry       <= 1'b0;
    end else if (clear) begin
      timer       <= '0;
      retry_count <= '0;
      retry       <= 1'b0;
    end else begin
      retry <= 1'b0;
      if (timeout) begin
        // On exhaustion the FSM leaves NAVIGATE; counters hold for observation.
        if (!at_max) begin
          retry_count <= retry_count + 1'b1;
          timer       <= '0;
          retry       <= 1'b1;
        end
      end else if (enable && !hit) begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mission_sequencer.sv
// Multi-waypoint inspection mission FSM: navigate / inspect / transmit per
// waypoint, with navigation watchdog, abort path and per-waypoint health log.
module mission_sequencer
  import mission_pkg::*;
#(
  parameter int NUM_WAYPOINTS = 4,
  parameter int NAV_TIMEOUT   = 1000,
  parameter int MAX_RETRIES   = 2,
  parameter int HEALTH_W      = 2,
  parameter bit ABORT_ON_CRIT = 1'b0,
  localparam int IDX_W = (NUM_WAYPOINTS > 1) ? $clog2(NUM_WAYPOINTS) : 1,
  localparam int RC_W  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          target_reached,
  input  logic                          inspection_complete,
  input  logic [HEALTH_W-1:0]           health_status_in,
  input  logic                          transmission_complete,
  input  logic                          finished,
  output logic [2:0]                    state_enc,
  output logic [IDX_W-1:0]              waypoint_idx,
  output logic [HEALTH_W-1:0]           health_status_out,
  output logic [NUM_WAYPOINTS*HEALTH_W-1:0] health_log,
  output logic [RC_W-1:0]               retry_count,
  output logic                          nav_retry,
  output logic                          fault
);

  // Phase inputs are level strobes with no ready: each is sampled only in its
  // own state, and acceptance is the state change on the following edge.

  localparam logic [HEALTH_W-1:0] CRIT_CODE = HEALTH_W'(HEALTH_CRIT);
  localparam logic [HEALTH_W-1:0] OK_CODE   = HEALTH_W'(HEALTH_OK);

  mission_state_e state_q, state_d;

  logic wd_clear;
  logic wd_enable;
  logic wd_exhausted;
  logic clr_mission;
  logic ld_health;
  logic inc_idx;
  logic last_wp;

  assign last_wp   = (waypoint_idx == IDX_W'(NUM_WAYPOINTS - 1));
  assign wd_enable = (state_q == ST_NAVIGATE) && !abort;
  assign state_enc = state_q;

  nav_watchdog #(
    .NAV_TIMEOUT (NAV_TIMEOUT),
    .MAX_RETRIES (MAX_RETRIES),
    .RC_W        (RC_W)
  ) u_watchdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (wd_clear),
    .enable      (wd_enable),
    .hit         (target_reached),
    .retry       (nav_retry),
    .exhausted   (wd_exhausted),
    .retry_count (retry_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      fault   <= (state_d == ST_FAULT);
    end
  end

  always_comb begin
    state_d     = state_q;
    wd_clear    = 1'b0;
    clr_mission = 1'b0;
    ld_health   = 1'b0;
    inc_idx     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_NAVIGATE;
          clr_mission = 1'b1;
          wd_clear    = 1'b1;
        end
      end
      ST_NAVIGATE: begin
        if (abort)               state_d = ST_FAULT;
        else if (target_reached) state_d = ST_INSPECT;
        else if (wd_exhausted)   state_d = ST_FAULT;
      end
      ST_INSPECT: begin
        if (abort) begin
          state_d = ST_FAULT;
        end else if (inspection_complete) begin
          ld_health = 1'b1;
          if (ABORT_ON_CRIT && (health_status_in == CRIT_CODE)) state_d = ST_FAULT;
          else                                                 state_d = ST_TRANSMIT;
        end
      end
      ST_TRANSMIT: begin
        if (abort) begin
          state_d = ST_FAULT;
        end else if (transmission_complete) begin
          if (last_wp) begin
            state_d = ST_COMPLETE;
          end else begin
            state_d  = ST_NAVIGATE;
            inc_idx  = 1'b1;
            wd_clear = 1'b1;
          end
        end
      end
      ST_COMPLETE: begin
        if (abort)         state_d = ST_FAULT;
        else if (finished) state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (finished) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Mission results persist through COMPLETE/FAULT/IDLE until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waypoint_idx      <= '0;
      health_log        <= '0;
      health_status_out <= OK_CODE;
    end else if (clr_mission) begin
      waypoint_idx      <= '0;
      health_log        <= '0;
      health_status_out <= OK_CODE;
    end else begin
      if (ld_health) begin
        health_log[int'(waypoint_idx)*HEALTH_W +: HEALTH_W] <= health_status_in;
        health_status_out <= HEALTH_W'(max_health(HEALTH_MAX_W'(health_status_out),
                                                  HEALTH_MAX_W'(health_status_in)));
      end
      if (inc_idx) waypoint_idx <= waypoint_idx + 1'b1;
    end
  end

endmodule
